// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------+
// | mem_pkg                                                              |
// | Shared FSM states, wait counter width and lane helper for the data   |
// | memory controller.                                                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Zero-extended byte from lane 0..3 of a word (lane 0 = bits 7:0).
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return {24'd0, shifted[7:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// +----------------------------------------------------------------------+
// | mem_array                                                            |
// | Single-port word storage: synchronous byte-enabled write,            |
// | combinational read.                                                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Contents start at zero and are deliberately never touched by reset.
  logic [31:0] r_mem [DEPTH] = '{default: 32'd0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// +----------------------------------------------------------------------+
// | data_mem_ctrl                                                        |
// | Wait-stated data memory controller with byte/word access and         |
// | out-of-range detection.                                              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic        byte_mode,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] MEM_result,
  output logic        ready,
  output logic        addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd;
  logic             r_wr;
  logic             r_byte;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;

  logic [31:0]      w_offset;
  logic [31:0]      w_index;
  logic             w_in_range;
  logic             w_fire;
  logic             w_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rword;
  logic [31:0]      w_rval;

  assign w_offset   = r_addr - 32'(BASE_ADDR);
  assign w_index    = w_offset >> 2;
  assign w_in_range = (r_addr >= 32'(BASE_ADDR)) && (w_index < 32'(DEPTH));

  // The access happens on the last WAIT edge; a simultaneous read+write is a read.
  assign w_fire  = (r_state == WAIT) && (r_cnt == CNT_W'(1));
  assign w_we    = w_fire && r_wr && !r_rd && w_in_range;
  assign w_be    = r_byte ? (4'b0001 << r_addr[1:0]) : 4'b1111;
  assign w_wdata = r_byte ? {4{r_data[7:0]}} : r_data;
  assign w_rval  = r_byte ? lane_extract(w_rword, r_addr[1:0]) : w_rword;

  assign ready = ((r_state == IDLE) && !(MEMread || MEMwrite)) || (r_state == DONE);

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (w_we),
    .be    (w_be),
    .addr  (w_index[AW-1:0]),
    .wdata (w_wdata),
    .rdata (w_rword)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_byte     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      MEM_result <= '0;
      addr_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MEMread || MEMwrite) begin
            r_rd    <= MEMread;
            r_wr    <= MEMwrite;
            r_byte  <= byte_mode;
            r_addr  <= address;
            r_data  <= data;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_fire) begin
            addr_err <= !w_in_range;
            if (r_rd) MEM_result <= w_in_range ? w_rval : 32'd0;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
